// File: rtl/float_dot_pkg.sv
// float_dot_pkg: shared state encoding and float word helpers for the dot-product sequencer
package float_dot_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, CAPTURE} state_t;
  function automatic int floatWidth(input int exp_w, input int frac_w);
    return 1 + exp_w + frac_w;
  endfunction
  function automatic logic [63:0] zeroWord();
    return '0;
  endfunction
endpackage

// File: rtl/float_result_slot.sv
// float_result_slot: one-entry valid/ready holding register for the captured sum and element count
module float_result_slot #(
  parameter int W  = 14,
  parameter int CW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_load,
  input  logic [W-1:0]  i_data,
  input  logic [CW-1:0] i_count,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_count,
  output logic          o_free
);
  logic          r_valid;
  logic [W-1:0]  r_data;
  logic [CW-1:0] r_count;
  assign o_free  = !r_valid | i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_count = r_count;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_count <= i_count;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/float_dot_sequencer.sv
// float_dot_sequencer: frames (a,b) pairs into vectors for a free-running MAC and captures each dot product
module float_dot_sequencer
  import float_dot_pkg::*;
#(
  parameter int EXP_IN_A    = 3,
  parameter int FRAC_IN_A   = 2,
  parameter int EXP_IN_B    = 3,
  parameter int FRAC_IN_B   = 2,
  parameter int EXP_OUT     = 5,
  parameter int FRAC_OUT    = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       inValid,
  output logic                                       inReady,
  input  logic                                       inLast,
  input  logic [floatWidth(EXP_IN_A, FRAC_IN_A)-1:0] inA,
  input  logic [floatWidth(EXP_IN_B, FRAC_IN_B)-1:0] inB,
  output logic [floatWidth(EXP_IN_A, FRAC_IN_A)-1:0] macA,
  output logic [floatWidth(EXP_IN_B, FRAC_IN_B)-1:0] macB,
  output logic [floatWidth(EXP_OUT, FRAC_OUT)-1:0]   macAccIn,
  input  logic [floatWidth(EXP_OUT, FRAC_OUT)-1:0]   macAccOut,
  output logic                                       resultValid,
  input  logic                                       resultReady,
  output logic [floatWidth(EXP_OUT, FRAC_OUT)-1:0]   result,
  output logic [COUNT_WIDTH-1:0]                     resultCount
);
  localparam int WA = floatWidth(EXP_IN_A, FRAC_IN_A);
  localparam int WB = floatWidth(EXP_IN_B, FRAC_IN_B);
  localparam int WO = floatWidth(EXP_OUT, FRAC_OUT);
  localparam logic [WA-1:0] ZA = WA'(zeroWord());
  localparam logic [WB-1:0] ZB = WB'(zeroWord());
  localparam logic [WO-1:0] ZO = WO'(zeroWord());
  state_t                 r_state, w_next;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   w_free, w_accept, w_first, w_load, w_sat;
  assign w_sat = &r_count;
  always_ff @(posedge clock) begin
    r_state <= reset ? IDLE : w_next;
  end
  always_comb begin
    w_next = r_state;
    if (w_first) w_next = w_accept ? (inLast ? CAPTURE : ACCUM) : IDLE;
    else if (r_state == ACCUM && w_accept && inLast) w_next = CAPTURE;
  end
  // A free slot in CAPTURE both drains the finished sum and opens the next vector
  always_comb begin
    inReady  = reset ? 1'b0 : r_state == CAPTURE ? w_free : r_state == ACCUM ? !w_sat : 1'b1;
    w_accept = inValid & inReady;
    w_first  = r_state == IDLE || (r_state == CAPTURE && w_free);
    w_load   = !reset && r_state == CAPTURE && w_free;
    macA     = w_accept ? inA : ZA;
    macB     = w_accept ? inB : ZB;
    macAccIn = (reset || w_first) ? ZO : macAccOut;
  end
  always_ff @(posedge clock) begin
    if (reset) r_count <= '0;
    else if (w_accept) r_count <= w_first ? COUNT_WIDTH'(1) : r_count + COUNT_WIDTH'(1);
  end
  float_result_slot #(.W(WO), .CW(COUNT_WIDTH)) u_slot (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_load),
    .i_data  (macAccOut),
    .i_count (r_count),
    .i_ready (resultReady),
    .o_valid (resultValid),
    .o_data  (result),
    .o_count (resultCount),
    .o_free  (w_free)
  );
endmodule

// File: doc/float_dot_sequencer.md
Name: float_dot_sequencer

Overview:
- Streaming controller placed directly upstream of the single-cycle float multiply-accumulate stage (acc' = acc + a*b; accumulator output registered, 1-cycle latency).
- Accepts (a, b) operand pairs with valid/ready/last framing and drives the MAC operand and accumulator-input buses.
- Zero-seeds the accumulator at the start of each vector and captures the final sum into a result slot with a valid/ready handshake.
- Turns the free-running MAC into a vector dot-product engine, with back-to-back vectors and no bubble when the result slot is drained.

Parameters:
- EXP_IN_A, 3, exponent width of operand a
- FRAC_IN_A, 2, fraction width of operand a
- EXP_IN_B, 3, exponent width of operand b
- FRAC_IN_B, 2, fraction width of operand b
- EXP_OUT, 5, exponent width of the accumulator/result
- FRAC_OUT, 8, fraction width of the accumulator/result
- COUNT_WIDTH, 16, width of the element counter; maximum vector length is 2^COUNT_WIDTH-1

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- inValid  in  1  operand pair valid
- inReady  out  1  sequencer accepts the pair this cycle
- inLast  in  1  pair is the final element of its vector
- inA  in  1+EXP_IN_A+FRAC_IN_A  operand a, packed {sign, exp, frac}
- inB  in  1+EXP_IN_B+FRAC_IN_B  operand b, packed {sign, exp, frac}
- macA  out  1+EXP_IN_A+FRAC_IN_A  to MAC a
- macB  out  1+EXP_IN_B+FRAC_IN_B  to MAC b
- macAccIn  out  1+EXP_OUT+FRAC_OUT  to MAC accumulator input
- macAccOut  in  1+EXP_OUT+FRAC_OUT  registered MAC sum
- resultValid  out  1  result slot full
- resultReady  in  1  consumer takes the result
- result  out  1+EXP_OUT+FRAC_OUT  captured dot product
- resultCount  out  COUNT_WIDTH  number of elements in the captured vector

Behaviour:
- Reset (synchronous, active-high) forces state IDLE, resultValid=0, result=0, resultCount=0, internal counter=0.
- Reset mid-vector or mid-capture discards the partial sum. While reset is high, inReady=0, macA=macB=0 and macAccIn=0.
- Accept condition: accept = inValid & inReady.
- Mux rules:
  - On accept: macA=inA, macB=inB.
  - Otherwise: macA=macB=+0 (all-zero word), a hold product.
  - macAccIn = +0 when the accepted pair is the first of a vector (state IDLE); otherwise macAccIn = macAccOut.
- Known hold artefact: holding adds +0. An accumulated -0 therefore becomes +0 under RNE. This is accepted.
- State IDLE:
  - inReady=1.
  - On accept: counter=1; next state is CAPTURE if inLast, else ACCUM.
- State ACCUM:
  - inReady=1.
  - On accept: counter+1; next state CAPTURE if inLast.
  - With no accept, the MAC holds via the zero product.
- State CAPTURE: macAccOut holds the final sum in this cycle.
  - Slot free = !resultValid | resultReady.
  - Slot free: load result=macAccOut and resultCount=counter, set resultValid, set inReady=1. An accepted pair in the same cycle starts a new vector (counter=1, macAccIn=+0, next state ACCUM or CAPTURE per inLast). With no accept, next state is IDLE.
  - Slot not free: inReady=0, MAC held (zero product, macAccIn=macAccOut), stay in CAPTURE.
- Counter saturation: if counter reaches 2^COUNT_WIDTH-1 in ACCUM, inReady=0 until the vector is closed. The upstream block must not exceed the maximum vector length.
- Latency: last pair accepted in cycle t gives resultValid=1 from cycle t+2 when the slot is free.
- Throughput: one pair per cycle. Single-element vectors can stream continuously while resultReady=1.
- resultValid clears on resultReady with no new capture in the same cycle.
- result and resultCount are stable while resultValid & !resultReady.
- NaN/Inf propagate through the MAC untouched; the sequencer does not inspect values.

Decomposition:
- Package float_dot_pkg holds:
  - state enum {IDLE, ACCUM, CAPTURE}
  - width functions floatWidth(exp, frac) = 1+exp+frac
  - constant zero-word function
- Sub-module float_result_slot: one-entry valid/ready register holding result and resultCount, with "free" output.
- FSM, counter and muxes live in the top module.
- Bench connects the DUT to the real MAC stage.

Test Plan:
- Numeric encoding: a/b use EXP=3, FRAC=2, bias 3; accumulator uses EXP=5, FRAC=8, bias 15.
- Vector [1.0*2.0, 1.5*2.0, 0.5*4.0], back-to-back, resultReady=1 -> result 7.0 (0_10001_11000000), resultCount=3, resultValid exactly 2 cycles after the last accept.
- Single-element vectors 1.0*1.0, then 2.0*2.0, on consecutive cycles with resultReady=1 -> results 1.0 then 4.0 on consecutive cycles. No bubble on inReady, and the second sum is not polluted by the first.
- Vector [1.0*1.0, bubble 3 cycles, 1.0*1.0 last] -> result 2.0, count 2; zero-hold preserves the sum.
- resultReady=0 with two 1-element vectors (3.0, 5.0) -> first result 3.0 held. inReady=0 while in CAPTURE with slot full. After resultReady pulses, 5.0 is captured and presented next.
- Reset asserted mid-vector after 2 pairs, then vector [2.0*1.0 last] -> result 2.0, count 1. No valid result is produced during or after the reset.
- COUNT_WIDTH=2, vector of 3 pairs with the last flag withheld -> inReady drops after the 3rd accept. Closing requires a further pair, which stays stalled; the bench checks inReady=0 holds.
